// File: rtl/cache_controller_request_scheduler_if.sv
// Stage-1 request scheduler bus: source queue heads, MSHR lookup ports,
// downstream occupancy/backpressure and the registered stage-1 request.
interface cache_controller_request_scheduler_if #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned MSHR_IDX_W = 2,
    parameter int unsigned TID_W      = 2,
    parameter int unsigned SRC_W      = 4
);
    logic                    rsp_valid;
    logic [ADDR_W-1:0]       rsp_address;
    logic                    rsp_dequeue;
    logic                    fwd_valid;
    logic [ADDR_W-1:0]       fwd_address;
    logic [SRC_W-1:0]        fwd_source;
    logic                    fwd_dequeue;
    logic                    core_valid;
    logic [ADDR_W-1:0]       core_address;
    logic [TID_W-1:0]        core_thread_id;
    logic                    core_dequeue;
    logic [3*ADDR_W-1:0]     mshr_lookup_address;
    logic [2:0]              mshr_lookup_hit;
    logic [3*MSHR_IDX_W-1:0] mshr_lookup_index;
    logic                    mshr_full;
    logic                    cc2_pending_valid;
    logic [ADDR_W-1:0]       cc2_pending_address;
    logic                    cc3_pending_valid;
    logic [ADDR_W-1:0]       cc3_pending_address;
    logic                    pipe_stall;
    logic                    cc1_request_valid;
    logic [1:0]              cc1_request_type;
    logic [ADDR_W-1:0]       cc1_request_address;
    logic [TID_W-1:0]        cc1_request_thread_id;
    logic [SRC_W-1:0]        cc1_request_source;
    logic                    cc1_request_mshr_hit;
    logic [MSHR_IDX_W-1:0]   cc1_request_mshr_index;

    modport slave (
        input  rsp_valid, rsp_address, fwd_valid, fwd_address, fwd_source,
               core_valid, core_address, core_thread_id,
               mshr_lookup_hit, mshr_lookup_index, mshr_full,
               cc2_pending_valid, cc2_pending_address,
               cc3_pending_valid, cc3_pending_address, pipe_stall,
        output rsp_dequeue, fwd_dequeue, core_dequeue, mshr_lookup_address,
               cc1_request_valid, cc1_request_type, cc1_request_address,
               cc1_request_thread_id, cc1_request_source,
               cc1_request_mshr_hit, cc1_request_mshr_index
    );

    modport master (
        output rsp_valid, rsp_address, fwd_valid, fwd_address, fwd_source,
               core_valid, core_address, core_thread_id,
               mshr_lookup_hit, mshr_lookup_index, mshr_full,
               cc2_pending_valid, cc2_pending_address,
               cc3_pending_valid, cc3_pending_address, pipe_stall,
        input  rsp_dequeue, fwd_dequeue, core_dequeue, mshr_lookup_address,
               cc1_request_valid, cc1_request_type, cc1_request_address,
               cc1_request_thread_id, cc1_request_source,
               cc1_request_mshr_hit, cc1_request_mshr_index
    );
endinterface

// File: rtl/cache_controller_request_scheduler.sv
// L1 cache controller stage 1: arbitrates rsp > fwd > core (core promoted over fwd
// when starved), blocks on set hazards / MSHR state / stall, registers one grant per cycle.
module cache_controller_request_scheduler #(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned OFF_W        = 6,
    parameter int unsigned SET_W        = 6,
    parameter int unsigned MSHR_IDX_W   = 2,
    parameter int unsigned TID_W        = 2,
    parameter int unsigned SRC_W        = 4,
    parameter int unsigned STARVE_LIMIT = 16
) (
    input logic                                 clk,
    input logic                                 reset,
    cache_controller_request_scheduler_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_RSP  = 2'd1,
        REQ_FWD  = 2'd2,
        REQ_CORE = 2'd3
    } req_type_e;

    function automatic logic [SET_W-1:0] set_of(input logic [ADDR_W-1:0] a);
        return a[OFF_W+SET_W-1:OFF_W];
    endfunction

    function automatic logic hazard(input logic [ADDR_W-1:0] a,
                                    input logic v2, input logic [ADDR_W-1:0] a2,
                                    input logic v3, input logic [ADDR_W-1:0] a3);
        return (v2 && set_of(a) == set_of(a2)) || (v3 && set_of(a) == set_of(a3));
    endfunction

    logic                  elig_rsp, elig_fwd, elig_core, starving;
    req_type_e             grant;
    logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
    logic                  valid_q, valid_d, hit_q, hit_d;
    logic [1:0]            type_q, type_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [TID_W-1:0]      tid_q, tid_d;
    logic [SRC_W-1:0]      src_q, src_d;
    logic [MSHR_IDX_W-1:0] idx_q, idx_d;
    logic                  unused_pending_bits;

    // Only the set-index bits of the pending addresses take part in hazard checks.
    assign unused_pending_bits = ^{bus.cc2_pending_address, bus.cc3_pending_address};

    assign bus.mshr_lookup_address = {bus.core_address, bus.fwd_address, bus.rsp_address};

    assign starving = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    always_comb begin
        elig_rsp  = bus.rsp_valid
                  && !hazard(bus.rsp_address, bus.cc2_pending_valid, bus.cc2_pending_address,
                             bus.cc3_pending_valid, bus.cc3_pending_address);
        elig_fwd  = bus.fwd_valid && !bus.mshr_lookup_hit[1]
                  && !hazard(bus.fwd_address, bus.cc2_pending_valid, bus.cc2_pending_address,
                             bus.cc3_pending_valid, bus.cc3_pending_address);
        elig_core = bus.core_valid && !bus.mshr_lookup_hit[2] && !bus.mshr_full
                  && !hazard(bus.core_address, bus.cc2_pending_valid, bus.cc2_pending_address,
                             bus.cc3_pending_valid, bus.cc3_pending_address);
    end

    always_comb begin
        grant = REQ_NONE;
        if (!bus.pipe_stall) begin
            if (elig_rsp)                   grant = REQ_RSP;
            else if (starving && elig_core) grant = REQ_CORE;
            else if (elig_fwd)              grant = REQ_FWD;
            else if (elig_core)             grant = REQ_CORE;
        end
    end

    // Dequeues are gated by reset so an in-flight grant never pops a head.
    assign bus.rsp_dequeue  = (grant == REQ_RSP)  && !reset;
    assign bus.fwd_dequeue  = (grant == REQ_FWD)  && !reset;
    assign bus.core_dequeue = (grant == REQ_CORE) && !reset;

    always_comb begin
        valid_d = 1'b0;
        type_d  = type_q;
        addr_d  = addr_q;
        tid_d   = tid_q;
        src_d   = src_q;
        hit_d   = hit_q;
        idx_d   = idx_q;
        case (grant)
            REQ_RSP: begin
                valid_d = 1'b1;
                type_d  = REQ_RSP;
                addr_d  = bus.rsp_address;
                tid_d   = '0;
                src_d   = '0;
                hit_d   = bus.mshr_lookup_hit[0];
                idx_d   = bus.mshr_lookup_index[0 +: MSHR_IDX_W];
            end
            REQ_FWD: begin
                valid_d = 1'b1;
                type_d  = REQ_FWD;
                addr_d  = bus.fwd_address;
                tid_d   = '0;
                src_d   = bus.fwd_source;
                hit_d   = bus.mshr_lookup_hit[1];
                idx_d   = bus.mshr_lookup_index[MSHR_IDX_W +: MSHR_IDX_W];
            end
            REQ_CORE: begin
                valid_d = 1'b1;
                type_d  = REQ_CORE;
                addr_d  = bus.core_address;
                tid_d   = bus.core_thread_id;
                src_d   = '0;
                hit_d   = bus.mshr_lookup_hit[2];
                idx_d   = bus.mshr_lookup_index[2*MSHR_IDX_W +: MSHR_IDX_W];
            end
            default: ;
        endcase
    end

    // Counts every cycle a waiting core head is passed over, stall cycles included.
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!bus.core_valid || grant == REQ_CORE) starve_cnt_d = '0;
        else if (!starving)                       starve_cnt_d = starve_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q <= '0;
            valid_q      <= 1'b0;
            type_q       <= '0;
            addr_q       <= '0;
            tid_q        <= '0;
            src_q        <= '0;
            hit_q        <= 1'b0;
            idx_q        <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            valid_q      <= valid_d;
            type_q       <= type_d;
            addr_q       <= addr_d;
            tid_q        <= tid_d;
            src_q        <= src_d;
            hit_q        <= hit_d;
            idx_q        <= idx_d;
        end
    end

    assign bus.cc1_request_valid      = valid_q;
    assign bus.cc1_request_type       = type_q;
    assign bus.cc1_request_address    = addr_q;
    assign bus.cc1_request_thread_id  = tid_q;
    assign bus.cc1_request_source     = src_q;
    assign bus.cc1_request_mshr_hit   = hit_q;
    assign bus.cc1_request_mshr_index = idx_q;

    // A response must always find its MSHR entry.
    rsp_hits_mshr_a: assert property (@(posedge clk) disable iff (reset)
        bus.rsp_dequeue |-> bus.mshr_lookup_hit[0])
        else $error("response granted without MSHR hit");
endmodule

// File: tb/tb_cache_controller_request_scheduler.sv
// Scoreboard bench for the stage-1 request scheduler: directed scenarios plus
// randomized traffic checked against a priority/starvation reference model.
module tb_cache_controller_request_scheduler;
    localparam int LIMIT = 16;

    typedef struct packed {
        logic [1:0]  typ;
        logic [31:0] addr;
        logic [1:0]  tid;
        logic [3:0]  src;
        logic        hit;
        logic [1:0]  idx;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   starve = 0;
    exp_t exp_q[$];
    exp_t last = '0;

    cache_controller_request_scheduler_if bus ();

    cache_controller_request_scheduler dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.rsp_valid = 0; bus.rsp_address = '0;
        bus.fwd_valid = 0; bus.fwd_address = '0; bus.fwd_source = '0;
        bus.core_valid = 0; bus.core_address = '0; bus.core_thread_id = '0;
        bus.mshr_lookup_hit = 3'b001; bus.mshr_lookup_index = '0; bus.mshr_full = 0;
        bus.cc2_pending_valid = 0; bus.cc2_pending_address = '0;
        bus.cc3_pending_valid = 0; bus.cc3_pending_address = '0;
        bus.pipe_stall = 0;
    endtask

    function automatic bit same_set(input logic [31:0] a, input logic [31:0] b);
        return ((a >> 6) % 64) == ((b >> 6) % 64);
    endfunction

    function automatic bit blocked_by_pipe(input logic [31:0] a);
        return (bus.cc2_pending_valid && same_set(a, bus.cc2_pending_address))
            || (bus.cc3_pending_valid && same_set(a, bus.cc3_pending_address));
    endfunction

    // Returns 0 for no grant, else 1=rsp 2=fwd 3=core.
    function automatic int model_grant();
        bit elig[3];
        int order[3];
        if (bus.pipe_stall) return 0;
        elig[0] = bus.rsp_valid && !blocked_by_pipe(bus.rsp_address);
        elig[1] = bus.fwd_valid && !blocked_by_pipe(bus.fwd_address) && !bus.mshr_lookup_hit[1];
        elig[2] = bus.core_valid && !blocked_by_pipe(bus.core_address) && !bus.mshr_lookup_hit[2]
                  && !bus.mshr_full;
        if (starve == LIMIT) order = '{0, 2, 1};
        else                 order = '{0, 1, 2};
        for (int i = 0; i < 3; i++)
            if (elig[order[i]]) return order[i] + 1;
        return 0;
    endfunction

    // One cycle from a negedge: check dequeues against the model (and an optional
    // directed expectation), queue the expected registered request, advance.
    task automatic step(input int exp_deq);
        int g;
        logic [2:0] deq, mdeq;
        exp_t e;
        g = model_grant();
        #1;
        deq  = {bus.core_dequeue, bus.fwd_dequeue, bus.rsp_dequeue};
        mdeq = (g == 0) ? 3'b000 : 3'(1 << (g - 1));
        chk("dequeue", 128'(deq), 128'(mdeq));
        chk("lookup_addr", 128'(bus.mshr_lookup_address),
            128'({bus.core_address, bus.fwd_address, bus.rsp_address}));
        if (exp_deq >= 0) chk("directed_dequeue", 128'(deq), 128'(exp_deq));
        if (g != 0) begin
            e.typ  = 2'(g);
            e.addr = (g == 1) ? bus.rsp_address : (g == 2) ? bus.fwd_address : bus.core_address;
            e.tid  = (g == 3) ? bus.core_thread_id : 2'd0;
            e.src  = (g == 2) ? bus.fwd_source : 4'd0;
            e.hit  = bus.mshr_lookup_hit[g-1];
            e.idx  = bus.mshr_lookup_index[(g-1)*2 +: 2];
            exp_q.push_back(e);
        end
        if (!bus.core_valid || g == 3) starve = 0;
        else if (starve < LIMIT)       starve++;
        @(negedge clk);
    endtask

    function automatic logic [31:0] raddr();
        return (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 3)) << 6);
    endfunction

    // Monitor: registered requests must match the scoreboard in order.
    initial forever begin
        exp_t act, e;
        @(posedge clk);
        #1;
        if (!reset) begin
            act = {bus.cc1_request_type, bus.cc1_request_address, bus.cc1_request_thread_id,
                   bus.cc1_request_source, bus.cc1_request_mshr_hit, bus.cc1_request_mshr_index};
            if (bus.cc1_request_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_request", 128'(act), 128'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("request_payload", 128'(act), 128'(e));
                    last = e;
                end
            end else begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("missing_request_valid", 128'(0), 128'(1));
                end
                chk("idle_hold_addr", 128'(bus.cc1_request_address), 128'(last.addr));
            end
        end
    end

    initial begin
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 0;
        starve = 0;
        #1;
        chk("reset_valid", 128'(bus.cc1_request_valid), 0);
        chk("reset_type", 128'(bus.cc1_request_type), 0);
        chk("reset_addr", 128'(bus.cc1_request_address), 0);
        chk("reset_payload", 128'({bus.cc1_request_thread_id, bus.cc1_request_source,
            bus.cc1_request_mshr_hit, bus.cc1_request_mshr_index}), 0);
        @(negedge clk);

        // All three valid: rsp, then fwd, then core.
        bus.rsp_valid = 1; bus.rsp_address = 32'h0000_0040;
        bus.fwd_valid = 1; bus.fwd_address = 32'h0000_3080; bus.fwd_source = 4'h9;
        bus.core_valid = 1; bus.core_address = 32'h0000_50C0; bus.core_thread_id = 2'd2;
        bus.mshr_lookup_hit = 3'b001; bus.mshr_lookup_index = 6'b11_10_01;
        step(3'b001);
        bus.rsp_valid = 0;  step(3'b010);
        bus.fwd_valid = 0;  step(3'b100);
        bus.core_valid = 0; step(0);

        // Set hazard against stage 2.
        bus.core_valid = 1; bus.core_address = 32'h0000_1040;
        bus.cc2_pending_valid = 1; bus.cc2_pending_address = 32'h0000_2040;
        step(0);
        bus.cc2_pending_valid = 0; step(3'b100);
        bus.core_valid = 0; step(0);

        // MSHR full blocks core.
        bus.core_valid = 1; bus.mshr_full = 1; step(0);
        bus.mshr_full = 0; step(3'b100);
        bus.core_valid = 0; step(0);

        // Starvation: core promoted on cycle 17, fwd resumes after.
        bus.fwd_valid = 1; bus.core_valid = 1;
        for (int i = 1; i <= 17; i++) step((i == 17) ? 3'b100 : 3'b010);
        step(3'b010);
        bus.fwd_valid = 0; bus.core_valid = 0; step(0);

        // Pipe stall holds rsp.
        bus.rsp_valid = 1; bus.pipe_stall = 1; step(0);
        bus.pipe_stall = 0; step(3'b001);
        bus.rsp_valid = 0; step(0);

        // Reset in the middle of a core grant cycle.
        bus.core_valid = 1; bus.core_address = 32'h0000_7100; step(3'b100);
        #2;
        reset = 1;
        exp_q.delete();
        starve = 0;
        last = '0;
        #1;
        chk("rst_mid_core_dequeue", 128'(bus.core_dequeue), 0);
        chk("rst_mid_valid", 128'(bus.cc1_request_valid), 0);
        chk("rst_mid_type", 128'(bus.cc1_request_type), 0);
        chk("rst_mid_addr", 128'(bus.cc1_request_address), 0);
        @(negedge clk);
        reset = 0;
        // Core still waiting after reset; starvation count restarted from zero.
        bus.fwd_valid = 1; bus.fwd_address = 32'h0000_0200;
        for (int i = 1; i <= 17; i++) step((i == 17) ? 3'b100 : 3'b010);
        idle_inputs(); step(0);

        // Randomized traffic; second half leans on fwd to exercise starvation.
        for (int n = 0; n < 3000; n++) begin
            bit heavy;
            heavy = (n >= 1500);
            bus.rsp_valid  = ($urandom_range(0, 3) == 0);
            bus.fwd_valid  = heavy ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 1) == 0);
            bus.core_valid = ($urandom_range(0, 9) != 0);
            bus.rsp_address = raddr(); bus.fwd_address = raddr(); bus.core_address = raddr();
            bus.fwd_source = 4'($urandom);
            bus.core_thread_id = 2'($urandom);
            bus.mshr_lookup_hit = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), 1'b1};
            bus.mshr_lookup_index = 6'($urandom);
            bus.mshr_full = heavy ? 1'b0 : ($urandom_range(0, 3) == 0);
            bus.cc2_pending_valid = ($urandom_range(0, 9) < (heavy ? 1 : 3));
            bus.cc3_pending_valid = ($urandom_range(0, 9) < (heavy ? 1 : 3));
            bus.cc2_pending_address = raddr(); bus.cc3_pending_address = raddr();
            bus.pipe_stall = ($urandom_range(0, 9) < (heavy ? 1 : 2));
            step(-1);
        end

        idle_inputs();
        step(0);
        step(0);
        chk("scoreboard_drained", 128'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
